// File: rtl/axi_ddr_sim_slave.sv
// AXI slave standing in for the DDR controller in simulation: one read and one
// write burst in flight at once, fixed programmable latency, word-wide memory.
module axi_ddr_sim_slave #(
   parameter int MEM_WORDS     = 16384,
   parameter int READ_LATENCY  = 5,
   parameter int WRITE_LATENCY = 5,
   parameter int ID_W          = 6
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [31:0]                  ddr_axi_araddr,
   input  logic [1:0]                   ddr_axi_arburst,
   input  logic [ID_W-1:0]              ddr_axi_arid,
   input  logic [7:0]                   ddr_axi_arlen,
   input  logic [2:0]                   ddr_axi_arsize,
   input  logic                         ddr_axi_arvalid,
   output logic                         ddr_axi_arready,
   output logic [31:0]                  ddr_axi_rdata,
   output logic [ID_W-1:0]              ddr_axi_rid,
   output logic [1:0]                   ddr_axi_rresp,
   output logic                         ddr_axi_rlast,
   output logic                         ddr_axi_rvalid,
   input  logic                         ddr_axi_rready,
   input  logic [31:0]                  ddr_axi_awaddr,
   input  logic [1:0]                   ddr_axi_awburst,
   input  logic [ID_W-1:0]              ddr_axi_awid,
   input  logic [7:0]                   ddr_axi_awlen,
   input  logic [2:0]                   ddr_axi_awsize,
   input  logic                         ddr_axi_awvalid,
   output logic                         ddr_axi_awready,
   input  logic [31:0]                  ddr_axi_wdata,
   input  logic [3:0]                   ddr_axi_wstrb,
   input  logic                         ddr_axi_wlast,
   input  logic                         ddr_axi_wvalid,
   output logic                         ddr_axi_wready,
   output logic [ID_W-1:0]              ddr_axi_bid,
   output logic [1:0]                   ddr_axi_bresp,
   output logic                         ddr_axi_bvalid,
   input  logic                         ddr_axi_bready,
   input  logic                         init_we,
   input  logic [$clog2(MEM_WORDS)-1:0] init_addr,
   input  logic [31:0]                  init_data
);
   localparam int AW = $clog2(MEM_WORDS);
   localparam logic [7:0] RD_LAT = 8'(READ_LATENCY);
   localparam logic [7:0] WR_LAT = 8'(WRITE_LATENCY);

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;

   logic [31:0] mem [MEM_WORDS];

   function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] b,
                                             input logic [7:0] l);
      logic [31:0] mask;
      mask = {22'd0, l, 2'b11};
      case (b)
         2'd0:    next_addr = a;
         2'd2:    next_addr = (a & ~mask) | ((a + 32'd4) & mask);
         default: next_addr = a + 32'd4;
      endcase
   endfunction

   function automatic logic burst_bad(input logic [1:0] b, input logic [2:0] s,
                                      input logic [7:0] l);
      burst_bad = (s != 3'd2) || (b == 2'd3) ||
                  ((b == 2'd2) && !(l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15));
   endfunction

   function automatic logic [1:0] beat_resp(input logic [31:0] a, input logic slv);
      if ({2'b00, a[31:2]} >= 32'(MEM_WORDS)) beat_resp = 2'd3;
      else if (slv)                          beat_resp = 2'd2;
      else                                   beat_resp = 2'd0;
   endfunction

   // Response codes are ordered so that the numerically larger one is the worse one
   function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
      worst = (a > b) ? a : b;
   endfunction

   // ---------------- read channel ----------------
   r_state_t    r_state;
   logic [31:0] r_addr;
   logic [7:0]  r_len, r_beat, r_cnt;
   logic [1:0]  r_burst, r_resp;
   logic        r_slv;

   assign r_resp        = beat_resp(r_addr, r_slv);
   assign ddr_axi_rresp = ddr_axi_rvalid ? r_resp : 2'd0;
   assign ddr_axi_rlast = ddr_axi_rvalid && (r_beat == r_len);
   assign ddr_axi_rdata = (ddr_axi_rvalid && r_resp == 2'd0) ? mem[r_addr[AW+1:2]] : 32'd0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= R_IDLE;
         ddr_axi_arready <= 1'b0;
         ddr_axi_rvalid  <= 1'b0;
         ddr_axi_rid     <= '0;
         r_addr          <= '0;
         r_len           <= '0;
         r_beat          <= '0;
         r_cnt           <= '0;
         r_burst         <= '0;
         r_slv           <= 1'b0;
      end else begin
         case (r_state)
            R_IDLE: begin
               ddr_axi_arready <= 1'b1;
               if (ddr_axi_arvalid && ddr_axi_arready) begin
                  ddr_axi_arready <= 1'b0;
                  r_addr          <= ddr_axi_araddr;
                  r_len           <= ddr_axi_arlen;
                  r_burst         <= ddr_axi_arburst;
                  ddr_axi_rid     <= ddr_axi_arid;
                  r_slv           <= burst_bad(ddr_axi_arburst, ddr_axi_arsize, ddr_axi_arlen);
                  r_beat          <= '0;
                  r_cnt           <= RD_LAT;
                  if (RD_LAT == 8'd0) begin
                     r_state        <= R_BURST;
                     ddr_axi_rvalid <= 1'b1;
                  end else begin
                     r_state <= R_WAIT;
                  end
               end
            end
            R_WAIT: begin
               r_cnt <= r_cnt - 8'd1;
               if (r_cnt == 8'd1) begin
                  r_state        <= R_BURST;
                  ddr_axi_rvalid <= 1'b1;
               end
            end
            R_BURST: begin
               if (ddr_axi_rready) begin
                  r_addr <= next_addr(r_addr, r_burst, r_len);
                  r_beat <= r_beat + 8'd1;
                  if (ddr_axi_rlast) begin
                     ddr_axi_rvalid  <= 1'b0;
                     ddr_axi_arready <= 1'b1;
                     r_state         <= R_IDLE;
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   // ---------------- write channel ----------------
   w_state_t    w_state;
   logic [31:0] w_addr;
   logic [7:0]  w_len, w_cnt;
   logic [8:0]  w_beat;
   logic [1:0]  w_burst, w_worst, w_resp, w_final;
   logic        w_slv, w_fire;

   assign w_fire  = (w_state == W_DATA) && ddr_axi_wvalid && ddr_axi_wready;
   assign w_resp  = beat_resp(w_addr, w_slv);
   assign w_final = worst(worst(w_worst, w_resp),
                          (w_beat != {1'b0, w_len}) ? 2'd2 : 2'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_state         <= W_IDLE;
         ddr_axi_awready <= 1'b0;
         ddr_axi_wready  <= 1'b0;
         ddr_axi_bvalid  <= 1'b0;
         ddr_axi_bid     <= '0;
         ddr_axi_bresp   <= '0;
         w_addr          <= '0;
         w_len           <= '0;
         w_beat          <= '0;
         w_cnt           <= '0;
         w_burst         <= '0;
         w_worst         <= '0;
         w_slv           <= 1'b0;
      end else begin
         case (w_state)
            W_IDLE: begin
               ddr_axi_awready <= 1'b1;
               if (ddr_axi_awvalid && ddr_axi_awready) begin
                  ddr_axi_awready <= 1'b0;
                  ddr_axi_wready  <= 1'b1;
                  w_addr          <= ddr_axi_awaddr;
                  w_len           <= ddr_axi_awlen;
                  w_burst         <= ddr_axi_awburst;
                  ddr_axi_bid     <= ddr_axi_awid;
                  w_slv           <= burst_bad(ddr_axi_awburst, ddr_axi_awsize, ddr_axi_awlen);
                  w_beat          <= '0;
                  w_worst         <= '0;
                  w_state         <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_fire) begin
                  w_addr  <= next_addr(w_addr, w_burst, w_len);
                  w_beat  <= w_beat + 9'd1;
                  w_worst <= worst(w_worst, w_resp);
                  if (ddr_axi_wlast) begin
                     ddr_axi_wready <= 1'b0;
                     w_worst        <= w_final;
                     w_cnt          <= WR_LAT;
                     if (WR_LAT == 8'd0) begin
                        ddr_axi_bvalid <= 1'b1;
                        ddr_axi_bresp  <= w_final;
                        w_state        <= W_RESP;
                     end else begin
                        w_state <= W_WAIT;
                     end
                  end
               end
            end
            W_WAIT: begin
               w_cnt <= w_cnt - 8'd1;
               if (w_cnt == 8'd1) begin
                  ddr_axi_bvalid <= 1'b1;
                  ddr_axi_bresp  <= w_worst;
                  w_state        <= W_RESP;
               end
            end
            W_RESP: begin
               if (ddr_axi_bready) begin
                  ddr_axi_bvalid  <= 1'b0;
                  ddr_axi_awready <= 1'b1;
                  w_state         <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Backdoor preload is applied last so it wins over a same-word W beat
   always_ff @(posedge clk) begin
      if (w_fire && w_resp == 2'd0) begin
         for (int i = 0; i < 4; i++) begin
            if (ddr_axi_wstrb[i]) mem[w_addr[AW+1:2]][8*i +: 8] <= ddr_axi_wdata[8*i +: 8];
         end
      end
      if (init_we) mem[init_addr] <= init_data;
   end
endmodule

// File: doc/axi_ddr_sim_slave.md
Name: axi_ddr_sim_slave

Overview:
- Behavioural-but-synthesizable AXI slave model of the DDR controller.
- Sits directly downstream of the L2 AXI test harness and connects to its ddr_axi_* master ports.
- Services one read burst and one write burst concurrently, each with programmable fixed latency, over a word-organized internal memory.
- Used by the Verilator AXI_DDR simulation flow in place of a real controller.

Parameters:
MEM_WORDS, 16384, depth of the 32-bit memory array in words (power of two).
READ_LATENCY, 5, idle cycles between AR handshake and first R beat.
WRITE_LATENCY, 5, idle cycles between last W beat accepted and B valid.
ID_W, 6, AXI ID width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ddr_axi_araddr/arburst/arid/arlen/arsize  in  32/2/ID_W/8/3  read address channel
ddr_axi_arvalid  in  1 ; ddr_axi_arready  out  1
ddr_axi_rdata/rid/rresp  out  32/ID_W/2 ; ddr_axi_rlast/rvalid  out  1 ; ddr_axi_rready  in  1
ddr_axi_awaddr/awburst/awid/awlen/awsize  in  32/2/ID_W/8/3  write address channel
ddr_axi_awvalid  in  1 ; ddr_axi_awready  out  1
ddr_axi_wdata/wstrb  in  32/4 ; ddr_axi_wlast/wvalid  in  1 ; ddr_axi_wready  out  1
ddr_axi_bid/bresp  out  ID_W/2 ; ddr_axi_bvalid  out  1 ; ddr_axi_bready  in  1
init_we  in  1  backdoor preload strobe (testbench only)
init_addr  in  $clog2(MEM_WORDS)  preload word index
init_data  in  32  preload word

Behaviour:
- Reset (async, active-high): read and write FSMs go to IDLE. All valid/ready outputs are 0 while rst is high. rdata, rid, rresp, bid and bresp are 0. rlast is 0. Memory contents are not cleared. A burst in flight is abandoned with no response.
- Read FSM: R_IDLE -> R_WAIT -> R_BURST -> R_IDLE.
  - R_IDLE: arready=1. On arvalid, latch addr, id, len, burst and size.
  - If READ_LATENCY=0, go directly to R_BURST. Otherwise load the counter with READ_LATENCY and go to R_WAIT.
  - R_WAIT: decrement the counter each cycle and move to R_BURST when it reaches 0.
  - Timing: AR handshake at cycle T gives first rvalid at T+READ_LATENCY+1.
  - R_BURST: rvalid=1 and rid=latched id. rdata is the combinational mem read at the current address. rlast=1 when beat count == len.
  - On rvalid&rready, advance address and beat count. On the last beat, return to R_IDLE; arready is next high the following cycle.
  - rvalid/rdata hold stable while rready=0.
- Write FSM: W_IDLE -> W_DATA -> W_WAIT -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. Latch the AW fields.
  - W_DATA: wready=1. Each accepted beat writes byte lanes where wstrb[i]=1; the memory is updated on that clock edge.
  - wlast ends the burst regardless of count. Beat count != len+1 flags SLVERR.
  - W_WAIT: count WRITE_LATENCY cycles (skipped if 0).
  - Timing: wlast accepted at cycle T gives bvalid at T+WRITE_LATENCY+1.
  - W_RESP: bvalid=1 and bid=latched id until bready, then return to W_IDLE.
  - W beats arriving before the AW handshake are not accepted (wready=0).
- Address generation: word index = addr[31:2].
  - FIXED: address is unchanged per beat.
  - INCR: +4 per beat.
  - WRAP: +4 per beat, wrapping within an aligned block of (len+1)*4 bytes.
  - Burst type 3 (reserved) is treated as INCR with SLVERR.
- Responses:
  - OKAY=0. SLVERR=2 when size != 2, when a WRAP burst has len not in {1,3,7,15}, or on a wlast count mismatch. DECERR=3 when any beat's word index >= MEM_WORDS.
  - On error, reads return rdata=0 for the faulty beats but still return exactly len+1 beats. Errored write beats are dropped.
  - rresp is per beat. bresp is the worst response across the burst (DECERR > SLVERR > OKAY).
- Concurrency and priority:
  - Read and write FSMs are fully independent and may be active in the same cycle.
  - A read beat presented in the cycle a write beat commits to the same word returns the old data; the next cycle returns the new data.
  - init_we has priority over a same-cycle W write to the same word.
  - init_we is only used while both FSMs are idle.
- Addresses wrap at 2^32; the 8-bit len supports 256-beat bursts.

Test Plan:
- Preload words 0..3 = 0x11,0x22,0x33,0x44. AR INCR addr=0x0, len=3, id=5 -> rvalid first at T+6 with rdata 0x11,0x22,0x33,0x44, rid=5, rlast only on beat 4, rresp=0.
- AW INCR addr=0x100, len=1, id=2. W 0xAABBCCDD strb=0xF, then 0x12345678 strb=0x3 -> bvalid at T+6 with bid=2, bresp=0. Readback of 0x100/0x104 gives 0xAABBCCDD and 0x00005678 (prior 0).
- WRAP read addr=0x18, len=3 -> beats from word addresses 0x18, 0x1C, 0x10, 0x14.
- With rready held low for 3 cycles mid-burst, rdata and rlast are stable and no beat is lost. With bready low for 4 cycles, bvalid is held and awready stays 0.
- Read addr = MEM_WORDS*4, len=1 -> 2 beats with rdata=0 and rresp=3. A write burst with wlast on beat 1 of len=2 gives bresp=2.
- Assert rst during R_WAIT of a read and in W_DATA of a write -> all valid/ready outputs are 0 immediately. After release, a new read of a preloaded word returns its original value.
